// File: rtl/led_matrix_framebuffer_multi_pkg.sv
// Shared types and width helpers for the multi-buffered LED matrix framebuffer.
// Also holds the buffer-index selection used when three buffers rotate.
package led_matrix_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic {
        WR_OPEN  = 1'b0,
        WR_STALL = 1'b1
    } wr_state_t;

    function automatic int row_aw(input int rows, input int sections);
        return $clog2(rows / sections);
    endfunction

    function automatic int col_aw(input int cols);
        return $clog2(cols);
    endfunction

    function automatic int sect_aw(input int sections);
        return $clog2(sections);
    endfunction

    // Lowest buffer index that is neither the frame just published nor the one on display.
    function automatic buf_idx_t next_wr_buf(input buf_idx_t published, input buf_idx_t rd_next);
        buf_idx_t pick;
        pick = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if ((2'(i) != published) && (2'(i) != rd_next)) begin
                pick = 2'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/led_matrix_framebuffer_multi_if.sv
// Pixel-ingest, scan-driver and status signals of the framebuffer.
// master = ingest/driver side, slave = framebuffer.
interface led_matrix_framebuffer_multi_if
    import led_matrix_pkg::*;
#(
    parameter int PANEL_ROWS   = 64,
    parameter int PANEL_COLS   = 64,
    parameter int COLOR_DEPTH  = 8,
    parameter int NUM_SECTIONS = 2,
    parameter int CNT_W        = 16
);
    localparam int ROW_AW = row_aw(PANEL_ROWS, NUM_SECTIONS);
    localparam int COL_AW = col_aw(PANEL_COLS);

    logic                                  sync_in;
    logic                                  valid_in;
    logic [3*COLOR_DEPTH-1:0]              rgb_in;
    logic                                  wr_ready;
    logic                                  line_sync;
    logic [COL_AW-1:0]                     frame_column;
    logic                                  blank_en;
    logic [NUM_SECTIONS*3*COLOR_DEPTH-1:0] rgb_out;
    logic [ROW_AW-1:0]                     matrix_row;
    logic                                  frame_sync;
    logic [CNT_W-1:0]                      frames_published;
    logic [CNT_W-1:0]                      frames_dropped;
    logic                                  partial_err;

    modport master (
        output sync_in, valid_in, rgb_in, line_sync, frame_column, blank_en,
        input  wr_ready, rgb_out, matrix_row, frame_sync,
               frames_published, frames_dropped, partial_err
    );

    modport slave (
        input  sync_in, valid_in, rgb_in, line_sync, frame_column, blank_en,
        output wr_ready, rgb_out, matrix_row, frame_sync,
               frames_published, frames_dropped, partial_err
    );

endinterface

// File: rtl/led_matrix_framebuffer_multi_section_ram.sv
// Simple dual-port RAM for one scan section: one write port, one registered read port.
module led_matrix_section_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 6144,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/led_matrix_framebuffer_multi.sv
// N-buffered panel framebuffer: raster writes into per-section RAMs, parallel section reads,
// buffer rotation on frame_sync, partial-frame rejection and frame status counters.
module led_matrix_framebuffer_multi
    import led_matrix_pkg::*;
#(
    parameter int PANEL_ROWS   = 64,
    parameter int PANEL_COLS   = 64,
    parameter int COLOR_DEPTH  = 8,
    parameter int NUM_SECTIONS = 2,
    parameter int NUM_BUFFERS  = 3,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    led_matrix_framebuffer_multi_if.slave bus
);

    localparam int RPS       = PANEL_ROWS / NUM_SECTIONS;
    localparam int ROW_AW    = row_aw(PANEL_ROWS, NUM_SECTIONS);
    localparam int COL_AW    = col_aw(PANEL_COLS);
    localparam int SECT_AW   = sect_aw(NUM_SECTIONS);
    localparam int OFF_AW    = ROW_AW + COL_AW;
    localparam int WA_W      = OFF_AW + SECT_AW;
    localparam int PIX_W     = 3 * COLOR_DEPTH;
    localparam int RAM_AW    = 2 + OFF_AW;
    localparam int RAM_DEPTH = NUM_BUFFERS * RPS * PANEL_COLS;
    localparam logic [WA_W-1:0]   LAST_ADDR = WA_W'(PANEL_ROWS * PANEL_COLS - 1);
    localparam logic [ROW_AW-1:0] LAST_ROW  = ROW_AW'(RPS - 1);

    wr_state_t          r_state, w_state_next;
    logic [WA_W-1:0]    r_wr_addr, w_wr_addr_next;
    buf_idx_t           r_wr_buf, w_wr_buf_next;
    buf_idx_t           r_rd_buf, w_rd_buf_next;
    buf_idx_t           r_ready_buf, w_ready_buf_next;
    logic               r_rd_valid, w_rd_valid_next;
    logic               r_ready_valid, w_ready_valid_next;
    logic [CNT_W-1:0]   r_pub_cnt, w_pub_cnt_next;
    logic [CNT_W-1:0]   r_drop_cnt, w_drop_cnt_next;
    logic               r_partial_err;
    logic [ROW_AW-1:0]  r_frame_row;
    logic [ROW_AW-1:0]  r_matrix_row;
    logic               r_live;

    logic               w_accept;
    logic [WA_W-1:0]    w_eff_addr;
    logic               w_publish;
    logic               w_abort;
    logic               w_frame_sync;
    logic               w_consume;
    logic [RAM_AW-1:0]  w_ram_wr_addr;
    logic [RAM_AW-1:0]  w_ram_rd_addr;
    logic [PIX_W-1:0]   w_rd_q [NUM_SECTIONS];
    logic [NUM_SECTIONS*PIX_W-1:0] w_rgb_out;

    // A sync_in arriving with a pixel makes that pixel address 0 of the new frame.
    assign w_accept      = bus.valid_in & (r_state == WR_OPEN);
    assign w_eff_addr    = bus.sync_in ? '0 : r_wr_addr;
    assign w_publish     = w_accept & (w_eff_addr == LAST_ADDR);
    assign w_abort       = bus.sync_in & (r_wr_addr != '0) & ~w_publish;
    assign w_frame_sync  = bus.line_sync & (r_frame_row == LAST_ROW);
    assign w_consume     = w_frame_sync & r_ready_valid;
    assign w_ram_wr_addr = {r_wr_buf, w_eff_addr[OFF_AW-1:0]};
    assign w_ram_rd_addr = {r_rd_buf, r_frame_row, bus.frame_column};

    always_comb begin
        w_state_next       = r_state;
        w_wr_addr_next     = r_wr_addr;
        w_wr_buf_next      = r_wr_buf;
        w_rd_buf_next      = r_rd_buf;
        w_ready_buf_next   = r_ready_buf;
        w_rd_valid_next    = r_rd_valid;
        w_ready_valid_next = r_ready_valid;
        w_pub_cnt_next     = r_pub_cnt;
        w_drop_cnt_next    = r_drop_cnt;

        if (w_accept) begin
            w_wr_addr_next = w_publish ? '0 : w_eff_addr + 1'b1;
        end else if (bus.sync_in) begin
            w_wr_addr_next = '0;
        end

        if (w_consume) begin
            w_rd_buf_next      = r_ready_buf;
            w_rd_valid_next    = 1'b1;
            w_ready_valid_next = 1'b0;
        end

        if (w_publish) begin
            w_ready_buf_next   = r_wr_buf;
            w_ready_valid_next = 1'b1;
            if (r_pub_cnt != '1) begin
                w_pub_cnt_next = r_pub_cnt + 1'b1;
            end
            // A pending frame taken by frame_sync this same cycle is not lost.
            if (r_ready_valid && !w_consume && (r_drop_cnt != '1)) begin
                w_drop_cnt_next = r_drop_cnt + 1'b1;
            end
            if (NUM_BUFFERS == 2) begin
                w_state_next = WR_STALL;
            end else begin
                w_wr_buf_next = next_wr_buf(r_wr_buf, w_rd_buf_next);
            end
        end

        if ((r_state == WR_STALL) && w_consume) begin
            w_state_next  = WR_OPEN;
            w_wr_buf_next = r_ready_buf ^ 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= WR_OPEN;
            r_wr_addr     <= '0;
            r_wr_buf      <= '0;
            r_rd_buf      <= '0;
            r_ready_buf   <= '0;
            r_rd_valid    <= 1'b0;
            r_ready_valid <= 1'b0;
            r_pub_cnt     <= '0;
            r_drop_cnt    <= '0;
            r_partial_err <= 1'b0;
            r_frame_row   <= '0;
            r_matrix_row  <= '0;
            r_live        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wr_addr     <= w_wr_addr_next;
            r_wr_buf      <= w_wr_buf_next;
            r_rd_buf      <= w_rd_buf_next;
            r_ready_buf   <= w_ready_buf_next;
            r_rd_valid    <= w_rd_valid_next;
            r_ready_valid <= w_ready_valid_next;
            r_pub_cnt     <= w_pub_cnt_next;
            r_drop_cnt    <= w_drop_cnt_next;
            r_partial_err <= w_abort;
            r_live        <= r_rd_valid & ~bus.blank_en;
            if (bus.line_sync) begin
                r_frame_row  <= (r_frame_row == LAST_ROW) ? '0 : r_frame_row + 1'b1;
                r_matrix_row <= r_frame_row;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sect
            logic w_hit;
            if (NUM_SECTIONS == 1) begin : g_one
                assign w_hit = 1'b1;
            end else begin : g_many
                assign w_hit = (w_eff_addr[WA_W-1:OFF_AW] == SECT_AW'(gi));
            end

            led_matrix_section_ram #(
                .DATA_W (PIX_W),
                .DEPTH  (RAM_DEPTH),
                .ADDR_W (RAM_AW)
            ) u_ram (
                .clk       (clk),
                .i_wr_en   (w_accept & w_hit),
                .i_wr_addr (w_ram_wr_addr),
                .i_wr_data (bus.rgb_in),
                .i_rd_addr (w_ram_rd_addr),
                .o_rd_data (w_rd_q[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rgb_out = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (r_live) begin
                w_rgb_out[s*PIX_W +: PIX_W] = w_rd_q[s];
            end
        end
    end

    assign bus.rgb_out          = w_rgb_out;
    assign bus.wr_ready         = (r_state == WR_OPEN);
    assign bus.matrix_row       = r_matrix_row;
    assign bus.frame_sync       = w_frame_sync;
    assign bus.frames_published = r_pub_cnt;
    assign bus.frames_dropped   = r_drop_cnt;
    assign bus.partial_err      = r_partial_err;

endmodule

// File: tb/tb_led_matrix_framebuffer_multi.sv
// Bench for the framebuffer: three instances (triple, double, four-section) share one stimulus
// stream; read results go through an expected-value queue, positions come from a vector table.
module tb_led_matrix_framebuffer_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_in, valid_in, line_sync, blank_en;
    logic [23:0] rgb_in;
    logic [5:0]  frame_column;

    always #5 clk = ~clk;

    led_matrix_framebuffer_multi_if #(.NUM_SECTIONS(2)) if_a ();
    led_matrix_framebuffer_multi_if #(.NUM_SECTIONS(2)) if_b ();
    led_matrix_framebuffer_multi_if #(.NUM_SECTIONS(4)) if_c ();

    assign if_a.sync_in = sync_in;   assign if_b.sync_in = sync_in;   assign if_c.sync_in = sync_in;
    assign if_a.valid_in = valid_in; assign if_b.valid_in = valid_in; assign if_c.valid_in = valid_in;
    assign if_a.rgb_in = rgb_in;     assign if_b.rgb_in = rgb_in;     assign if_c.rgb_in = rgb_in;
    assign if_a.line_sync = line_sync; assign if_b.line_sync = line_sync; assign if_c.line_sync = line_sync;
    assign if_a.frame_column = frame_column; assign if_b.frame_column = frame_column;
    assign if_c.frame_column = frame_column;
    assign if_a.blank_en = blank_en; assign if_b.blank_en = blank_en; assign if_c.blank_en = blank_en;

    led_matrix_framebuffer_multi #(.NUM_SECTIONS(2), .NUM_BUFFERS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    led_matrix_framebuffer_multi #(.NUM_SECTIONS(2), .NUM_BUFFERS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    led_matrix_framebuffer_multi #(.NUM_SECTIONS(4), .NUM_BUFFERS(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    typedef struct {
        int          dut;
        int          sect;
        logic [23:0] val;
        string       name;
    } exp_t;

    typedef struct {
        int row;
        int col;
        int sect;
        int exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   lines = 0;
    int   a_low = 0;
    int   a_low_start;
    logic pe_a0, pe_a1, pe_b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_a.wr_ready !== 1'b1) a_low++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb_of(input int dut, input int sect);
        case (dut)
            0:       return if_a.rgb_out[sect*24 +: 24];
            1:       return if_b.rgb_out[sect*24 +: 24];
            default: return if_c.rgb_out[sect*24 +: 24];
        endcase
    endfunction

    // Pixel value written by this bench: frame tag in bits 23:12, raster index below.
    function automatic logic [23:0] px(input int tag, input int rps, input int sect, input int row, input int col);
        return 24'((tag << 12) | ((sect * rps + row) * 64 + col));
    endfunction

    task automatic push(input int dut, input int sect, input logic [23:0] val, input string name);
        exp_t e;
        e.dut = dut; e.sect = sect; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic read_cycle(input int col);
        exp_t e;
        frame_column = 6'(col);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, rgb_of(e.dut, e.sect), e.val);
        end
    endtask

    task automatic line_pulse();
        line_sync = 1'b1;
        #1;
        chk("frame_sync_a", if_a.frame_sync, (lines % 32) == 31);
        chk("frame_sync_c", if_c.frame_sync, (lines % 16) == 15);
        tick();
        line_sync = 1'b0;
        chk("matrix_row_a", if_a.matrix_row, lines % 32);
        chk("matrix_row_c", if_c.matrix_row, lines % 16);
        lines++;
    endtask

    task automatic goto_row(input int row);
        while ((lines % 32) != row) line_pulse();
    endtask

    task automatic frame_sync_a();
        do line_pulse(); while ((lines % 32) != 0);
    endtask

    task automatic write_frame(input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            sync_in  = (i == 0);
            valid_in = 1'b1;
            rgb_in   = 24'((tag << 12) | i);
            tick();
            if (i == 0) begin
                pe_a0 = if_a.partial_err;
                pe_b0 = if_b.partial_err;
            end
            if (i == 1) pe_a1 = if_a.partial_err;
        end
        sync_in  = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sync_in = 0; valid_in = 0; rgb_in = '0; line_sync = 0; frame_column = '0; blank_en = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready_a", if_a.wr_ready, 1);
        chk("rst_wr_ready_b", if_b.wr_ready, 1);
        chk("rst_rgb_a", if_a.rgb_out, 0);
        chk("rst_rgb_c", if_c.rgb_out, 0);
        chk("rst_pub_a", if_a.frames_published, 0);
        chk("rst_drop_a", if_a.frames_dropped, 0);
        chk("rst_perr_a", if_a.partial_err, 0);
        chk("rst_mrow_a", if_a.matrix_row, 0);
        rst_n = 1'b1;
        lines = 0;
        tick();
    endtask

    initial begin
        tbl[0] = '{row: 3,  col: 5,  sect: 0, exp: 197};
        tbl[1] = '{row: 3,  col: 5,  sect: 1, exp: 2245};
        tbl[2] = '{row: 10, col: 0,  sect: 0, exp: 640};
        tbl[3] = '{row: 17, col: 33, sect: 1, exp: 3169};
        tbl[4] = '{row: 31, col: 63, sect: 0, exp: 2047};
        tbl[5] = '{row: 31, col: 63, sect: 1, exp: 4095};

        // Basic frame: pixel value = index, nothing shown before the first frame_sync.
        do_reset();
        write_frame(0, 4096);
        chk("t1_perr_clean_sync", pe_a0, 0);
        chk("t1_pub_a", if_a.frames_published, 1);
        chk("t1_pub_b", if_b.frames_published, 1);
        chk("t1_wr_ready_a", if_a.wr_ready, 1);
        chk("t1_wr_ready_b_stall", if_b.wr_ready, 0);
        repeat (31) line_pulse();
        push(0, 0, 24'd0, "t1_dark_a0"); push(0, 1, 24'd0, "t1_dark_a1"); push(1, 0, 24'd0, "t1_dark_b0");
        read_cycle(5);
        line_pulse();
        chk("t1_wr_ready_b_open", if_b.wr_ready, 1);
        push(2, 0, 24'd7, "t1_c_s0"); push(2, 1, 24'd1031, "t1_c_s1"); push(2, 3, 24'd3079, "t1_c_s3");
        push(0, 1, 24'd2055, "t1_a_s1_r0");
        read_cycle(7);
        for (int v = 0; v < 6; v++) begin
            goto_row(tbl[v].row);
            push(0, tbl[v].sect, 24'(tbl[v].exp), $sformatf("t1_tbl%0d_a", v));
            push(1, tbl[v].sect, 24'(tbl[v].exp), $sformatf("t1_tbl%0d_b", v));
            read_cycle(tbl[v].col);
        end

        // Three frames across two frame_syncs: triple buffer drops frame 2, double buffer stalls.
        do_reset();
        a_low_start = a_low;
        write_frame(1, 4096);
        frame_sync_a();
        write_frame(2, 4096);
        write_frame(3, 4096);
        chk("t2_pub_a", if_a.frames_published, 3);
        chk("t2_drop_a", if_a.frames_dropped, 1);
        chk("t2_pub_b", if_b.frames_published, 2);
        chk("t2_drop_b", if_b.frames_dropped, 0);
        chk("t2_wr_ready_b", if_b.wr_ready, 0);
        push(0, 0, px(1, 32, 0, 0, 9), "t2_a_old"); push(1, 0, px(1, 32, 0, 0, 9), "t2_b_old");
        read_cycle(9);
        frame_sync_a();
        chk("t2_wr_ready_b_open", if_b.wr_ready, 1);
        goto_row(7);
        push(0, 0, px(3, 32, 0, 7, 9), "t2_a_f3_s0"); push(0, 1, px(3, 32, 1, 7, 9), "t2_a_f3_s1");
        push(1, 0, px(2, 32, 0, 7, 9), "t2_b_f2_s0"); push(1, 1, px(2, 32, 1, 7, 9), "t2_b_f2_s1");
        read_cycle(9);
        chk("t2_a_never_stalled", a_low - a_low_start, 0);

        // Early sync_in after 100 pixels aborts; the following full frame publishes normally.
        do_reset();
        write_frame(1, 4096);
        frame_sync_a();
        write_frame(2, 100);
        write_frame(4, 4096);
        chk("t4_perr_pulse_a", pe_a0, 1);
        chk("t4_perr_pulse_b", pe_b0, 1);
        chk("t4_perr_one_cycle", pe_a1, 0);
        chk("t4_pub_a", if_a.frames_published, 2);
        chk("t4_pub_b", if_b.frames_published, 2);
        chk("t4_drop_a", if_a.frames_dropped, 0);
        push(0, 0, px(1, 32, 0, 0, 2), "t4_a_unchanged"); push(1, 0, px(1, 32, 0, 0, 2), "t4_b_unchanged");
        read_cycle(2);
        frame_sync_a();
        push(0, 0, px(4, 32, 0, 0, 0), "t4_a_pix0"); push(1, 0, px(4, 32, 0, 0, 0), "t4_b_pix0");
        read_cycle(0);
        goto_row(31);
        push(0, 1, px(4, 32, 1, 31, 63), "t4_a_last"); push(1, 1, px(4, 32, 1, 31, 63), "t4_b_last");
        read_cycle(63);

        // Publish in the same cycle as a frame_sync with nothing pending.
        do_reset();
        write_frame(5, 4095);
        repeat (31) line_pulse();
        valid_in = 1'b1; rgb_in = 24'((5 << 12) | 4095); line_sync = 1'b1;
        #1;
        chk("t6_coincident_fs", if_a.frame_sync, 1);
        tick();
        valid_in = 1'b0; line_sync = 1'b0; lines++;
        chk("t6_pub_a", if_a.frames_published, 1);
        chk("t6_pub_b", if_b.frames_published, 1);
        push(0, 0, 24'd0, "t6_a_pending"); push(1, 0, 24'd0, "t6_b_pending");
        read_cycle(1);
        frame_sync_a();
        push(0, 0, px(5, 32, 0, 0, 1), "t6_a_shown"); push(1, 0, px(5, 32, 0, 0, 1), "t6_b_shown");
        read_cycle(1);
        blank_en = 1'b1;
        push(0, 0, 24'd0, "t6_blank_a"); push(1, 1, 24'd0, "t6_blank_b");
        read_cycle(1);
        blank_en = 1'b0;
        push(0, 0, px(5, 32, 0, 0, 1), "t6_unblank_a");
        read_cycle(1);

        // Reset in the middle of a frame.
        line_pulse();
        write_frame(6, 500);
        rst_n = 1'b0;
        #1;
        chk("t6_midrst_rgb_a", if_a.rgb_out, 0);
        chk("t6_midrst_rgb_c", if_c.rgb_out, 0);
        chk("t6_midrst_ready_a", if_a.wr_ready, 1);
        chk("t6_midrst_pub_a", if_a.frames_published, 0);
        chk("t6_midrst_mrow_a", if_a.matrix_row, 0);
        do_reset();
        write_frame(7, 2000);
        frame_sync_a();
        chk("t6_incomplete_pub", if_a.frames_published, 0);
        push(0, 0, 24'd0, "t6_incomplete_dark_a"); push(1, 0, 24'd0, "t6_incomplete_dark_b");
        read_cycle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
